// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bit positions,
// FSM state encoding and the MEM/WB pipeline record.
package mem_stage_pkg;

  // m_MEM control bit positions
  localparam int M_BRANCH = 2;
  localparam int M_READ   = 1;
  localparam int M_WRITE  = 0;

  // wb_MEM / wb_WB control bit positions
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_res;
    logic [4:0]  rd;
    logic [1:0]  wb;
  } mem_wb_t;

  // Word accesses only: the two low address bits must be clear.
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: load takes a full record, bubble kills only the
// write-back controls and leaves the data fields as they were.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  mem_wb_t mem_wb_q;
  mem_wb_t mem_wb_d;

  always_comb begin
    mem_wb_d = mem_wb_q;
    if (bubble) begin
      mem_wb_d.wb[WB_REG_WRITE]  = 1'b0;
      mem_wb_d.wb[WB_MEM_TO_REG] = 1'b0;
    end else if (load) begin
      mem_wb_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign q = mem_wb_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses through a two-state FSM,
// stalls the front of the pipe while waiting, and feeds the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] res,
  input  logic        zero,
  input  logic [4:0]  write_register_ex,
  input  logic [31:0] write_data_ex,
  input  logic [2:0]  m_MEM,
  input  logic [1:0]  wb_MEM,
  mem_stage_if.master dmem,
  output logic        stall_mem,
  output logic        pc_src,
  output logic [31:0] read_data_wb,
  output logic [31:0] alu_res_wb,
  output logic [4:0]  rd_WB,
  output logic [1:0]  wb_WB,
  output logic        mem_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      addr_q,    addr_d;
  logic [31:0]      wdata_q,   wdata_d;
  logic             we_q,      we_d;
  logic             mem_err_q, mem_err_d;

  logic    access;
  logic    aligned;
  logic    wb_load;
  logic    wb_bubble;
  mem_wb_t wb_in;
  mem_wb_t wb_out;

  assign access  = m_MEM[M_READ] | m_MEM[M_WRITE];
  assign aligned = is_aligned(res[1:0]);

  // Branch resolution is independent of any memory activity.
  assign pc_src = m_MEM[M_BRANCH] & zero;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    mem_err_d = 1'b0;
    stall_mem = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;

    wb_in.read_data = wb_out.read_data;
    wb_in.alu_res   = res;
    wb_in.rd        = write_register_ex;
    wb_in.wb        = wb_MEM;

    unique case (state_q)
      IDLE: begin
        if (access && aligned) begin
          // Read+write together is a store.
          state_d   = BUSY;
          cnt_d     = '0;
          addr_d    = res;
          wdata_d   = write_data_ex;
          we_d      = m_MEM[M_WRITE];
          stall_mem = 1'b1;
          wb_bubble = 1'b1;
        end else if (access) begin
          mem_err_d = 1'b1;
          wb_bubble = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          wb_load = 1'b1;
          if (!we_q) begin
            wb_in.read_data = dmem.dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Give up: let the pipe move on with a killed instruction.
          state_d   = IDLE;
          mem_err_d = 1'b1;
          wb_bubble = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          stall_mem = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = (state_q == BUSY) & we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign mem_err         = mem_err_q;

  mem_wb_reg u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_in),
    .q      (wb_out)
  );

  assign read_data_wb = wb_out.read_data;
  assign alu_res_wb   = wb_out.alu_res;
  assign rd_WB        = wb_out.rd;
  assign wb_WB        = wb_out.wb;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues hand-computed MEM/WB
// results per instruction, the monitor pops them as each instruction retires.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] res;
  logic        zero;
  logic [4:0]  write_register_ex;
  logic [31:0] write_data_ex;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        stall_mem;
  logic        pc_src;
  logic [31:0] read_data_wb;
  logic [31:0] alu_res_wb;
  logic [4:0]  rd_WB;
  logic [1:0]  wb_WB;
  logic        mem_err;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .res               (res),
    .zero              (zero),
    .write_register_ex (write_register_ex),
    .write_data_ex     (write_data_ex),
    .m_MEM             (m_MEM),
    .wb_MEM            (wb_MEM),
    .dmem              (dmem_bus),
    .stall_mem         (stall_mem),
    .pc_src            (pc_src),
    .read_data_wb      (read_data_wb),
    .alu_res_wb        (alu_res_wb),
    .rd_WB             (rd_WB),
    .wb_WB             (wb_WB),
    .mem_err           (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        err;
    int          stalls;
    int          busy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic [31:0] alu,
                              input logic [4:0] rd, input logic [1:0] wb, input logic err,
                              input int stalls, input int busy, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.id = 0; e.rdata = rdata; e.alu = alu; e.rd = rd; e.wb = wb; e.err = err;
    e.stalls = stalls; e.busy = busy; e.we = we; e.addr = addr; e.wdata = wdata;
    return e;
  endfunction

  // Memory responder: acks on the ack_after-th cycle of a request.
  int          ack_after  = 0;
  logic        stray_ack  = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  int          resp_cnt   = 0;

  always @(posedge clk) begin
    #2;
    if (dmem_bus.dmem_req) begin
      resp_cnt++;
      dmem_bus.dmem_ack = (ack_after != 0) && (resp_cnt == ack_after);
    end else begin
      resp_cnt = 0;
      dmem_bus.dmem_ack = stray_ack;
    end
    dmem_bus.dmem_rdata = resp_rdata;
  end

  // Monitor: an instruction retires on any cycle sampled without stall.
  logic mon_en     = 1'b0;
  logic prev_go    = 1'b0;
  logic prev_stall = 1'b0;
  int   st_cnt     = 0;
  int   bz_cnt     = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic exp_err;
    if (rst || !mon_en) begin
      prev_go = 1'b0; prev_stall = 1'b0; st_cnt = 0; bz_cnt = 0;
    end else begin
      exp_err = 1'b0;
      if (prev_stall) chk("bubble wb_WB", {30'd0, wb_WB}, 32'd0);
      if (prev_go) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("v%0d read_data_wb", e.id), read_data_wb, e.rdata);
          chk($sformatf("v%0d alu_res_wb", e.id), alu_res_wb, e.alu);
          chk($sformatf("v%0d rd_WB", e.id), {27'd0, rd_WB}, {27'd0, e.rd});
          chk($sformatf("v%0d wb_WB", e.id), {30'd0, wb_WB}, {30'd0, e.wb});
          chk($sformatf("v%0d stall cycles", e.id), st_cnt, e.stalls);
          chk($sformatf("v%0d busy cycles", e.id), bz_cnt, e.busy);
          exp_err = e.err;
        end
        st_cnt = 0; bz_cnt = 0;
      end
      chk("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
      if (dmem_bus.dmem_req) begin
        if (sb.size() > 0) begin
          chk($sformatf("v%0d dmem_addr", sb[0].id), dmem_bus.dmem_addr, sb[0].addr);
          chk($sformatf("v%0d dmem_wdata", sb[0].id), dmem_bus.dmem_wdata, sb[0].wdata);
          chk($sformatf("v%0d dmem_we", sb[0].id), {31'd0, dmem_bus.dmem_we}, {31'd0, sb[0].we});
        end else begin
          chk("unexpected dmem_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        end
        bz_cnt++;
      end else begin
        chk("dmem_we idle", {31'd0, dmem_bus.dmem_we}, 32'd0);
      end
      if (stall_mem) st_cnt++;
      prev_go    = !stall_mem;
      prev_stall = stall_mem;
    end
  end

  // Present one instruction and hold it until the stage stops stalling.
  task automatic issue(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] r,
                       input logic [4:0] rd, input logic [31:0] wd, input logic z,
                       input int ack_n, input logic [31:0] rdat, input logic exp_pc,
                       input exp_t e);
    int guard;
    vec_id++;
    e.id = vec_id;
    m_MEM = m; wb_MEM = wb; res = r; write_register_ex = rd;
    write_data_ex = wd; zero = z; ack_after = ack_n; resp_rdata = rdat;
    sb.push_back(e);
    #1;
    chk($sformatf("v%0d pc_src", vec_id), {31'd0, pc_src}, {31'd0, exp_pc});
    guard = 0;
    @(negedge clk);
    while (stall_mem && guard < 40) begin
      guard++;
      @(negedge clk);
    end
    chk($sformatf("v%0d stall released", vec_id), {31'd0, stall_mem}, 32'd0);
    $display("issued v%0d m=%b wb=%b res=0x%08h rd=%0d", vec_id, m, wb, r, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " dmem_req"}, {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk({tag, " dmem_we"}, {31'd0, dmem_bus.dmem_we}, 32'd0);
    chk({tag, " dmem_addr"}, dmem_bus.dmem_addr, 32'd0);
    chk({tag, " dmem_wdata"}, dmem_bus.dmem_wdata, 32'd0);
    chk({tag, " mem_err"}, {31'd0, mem_err}, 32'd0);
    chk({tag, " stall_mem"}, {31'd0, stall_mem}, 32'd0);
    chk({tag, " read_data_wb"}, read_data_wb, 32'd0);
    chk({tag, " alu_res_wb"}, alu_res_wb, 32'd0);
    chk({tag, " rd_WB"}, {27'd0, rd_WB}, 32'd0);
    chk({tag, " wb_WB"}, {30'd0, wb_WB}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m_MEM = 3'b000; wb_MEM = 2'b00; res = 32'h0; write_register_ex = 5'd0;
    write_data_ex = 32'h0; zero = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // ALU op (zero set but not a branch)
    issue(3'b000, 2'b10, 32'h10, 5'd5, 32'h0, 1'b1, 0, 32'h0, 1'b0,
          mk(32'h0, 32'h10, 5'd5, 2'b10, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0));
    // Branch taken / not taken
    issue(3'b100, 2'b00, 32'h44, 5'd0, 32'h0, 1'b1, 0, 32'h0, 1'b1,
          mk(32'h0, 32'h44, 5'd0, 2'b00, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0));
    issue(3'b100, 2'b00, 32'h48, 5'd0, 32'h0, 1'b0, 0, 32'h0, 1'b0,
          mk(32'h0, 32'h48, 5'd0, 2'b00, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0));
    // Load, ack on 4th busy cycle
    issue(3'b010, 2'b11, 32'h100, 5'd7, 32'h55, 1'b0, 4, 32'hDEADBEEF, 1'b0,
          mk(32'hDEADBEEF, 32'h100, 5'd7, 2'b11, 1'b0, 4, 4, 1'b0, 32'h100, 32'h55));
    // Store, ack on 2nd busy cycle; read data must not be captured
    issue(3'b001, 2'b00, 32'h200, 5'd0, 32'h1234, 1'b0, 2, 32'hFFFF0000, 1'b0,
          mk(32'hDEADBEEF, 32'h200, 5'd0, 2'b00, 1'b0, 2, 2, 1'b1, 32'h200, 32'h1234));
    // Read+write set together behaves as a store, minimum latency
    issue(3'b011, 2'b01, 32'h300, 5'd3, 32'hA5A5, 1'b0, 1, 32'h11111111, 1'b0,
          mk(32'hDEADBEEF, 32'h300, 5'd3, 2'b01, 1'b0, 1, 1, 1'b1, 32'h300, 32'hA5A5));
    // Misaligned load: no request, error, bubble
    issue(3'b010, 2'b11, 32'h102, 5'd9, 32'h0, 1'b0, 1, 32'h77, 1'b0,
          mk(32'hDEADBEEF, 32'h300, 5'd3, 2'b00, 1'b1, 0, 0, 1'b0, 32'h0, 32'h0));
    // ALU op with a stray ack outside BUSY
    stray_ack = 1'b1;
    issue(3'b000, 2'b10, 32'hABC, 5'd12, 32'h0, 1'b0, 0, 32'h99999999, 1'b0,
          mk(32'hDEADBEEF, 32'hABC, 5'd12, 2'b10, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0));
    stray_ack = 1'b0;
    // Load that never gets an ack: abort after 15 busy cycles
    issue(3'b010, 2'b11, 32'h400, 5'd4, 32'h0, 1'b0, 0, 32'h0, 1'b0,
          mk(32'hDEADBEEF, 32'hABC, 5'd12, 2'b00, 1'b1, 15, 15, 1'b0, 32'h400, 32'h0));
    issue(3'b000, 2'b01, 32'h20, 5'd1, 32'h0, 1'b0, 0, 32'h0, 1'b0,
          mk(32'hDEADBEEF, 32'h20, 5'd1, 2'b01, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0));
    // Minimum-latency load
    issue(3'b010, 2'b11, 32'h104, 5'd8, 32'h0, 1'b0, 1, 32'hCAFEF00D, 1'b0,
          mk(32'hCAFEF00D, 32'h104, 5'd8, 2'b11, 1'b0, 1, 1, 1'b0, 32'h104, 32'h0));

    m_MEM = 3'b000; wb_MEM = 2'b00; res = 32'h0; write_register_ex = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 32'd0);
    mon_en = 1'b0;

    // Reset while an access is outstanding
    m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h500; write_register_ex = 5'd2;
    write_data_ex = 32'h0; ack_after = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy before reset", {31'd0, dmem_bus.dmem_req}, 32'd1);
    rst = 1'b1;
    m_MEM = 3'b000; wb_MEM = 2'b00; res = 32'h0; write_register_ex = 5'd0;
    @(negedge clk);
    check_all_zero("rst mid-busy");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
